// File: rtl/eeprom_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eeprom_arb_pkg : shared constants for the EEPROM bank arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
package eeprom_arb_pkg;

   localparam int DEV_W = 2;

   typedef logic [DEV_W-1:0] dev_t;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_F = 2'd1;
   localparam logic [1:0] GNT_U = 2'd2;
   localparam logic [1:0] GUARD = 2'd3;

   // Owner codes double as the sel1 mux value.
   localparam logic OWNER_F = 1'b0;
   localparam logic OWNER_U = 1'b1;

endpackage
`default_nettype wire

// File: rtl/eeprom_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eeprom_bus_arbiter : two-master req/gnt/rel arbiter for the EEPROM bank,
// with chip-select guard time and hold watchdog.   Revision 1.0
// ---------------------------------------------------------------------------
module eeprom_bus_arbiter
   import eeprom_arb_pkg::*;
#(
   parameter int GUARD_CYC = 4,
   parameter int HOLD_W    = 16,
   parameter int HOLD_MAX  = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_f,
   input  logic [DEV_W-1:0] dev_f,
   input  logic             rel_f,
   input  logic             req_u,
   input  logic [DEV_W-1:0] dev_u,
   input  logic             rel_u,
   output logic             gnt_f,
   output logic             gnt_u,
   output logic             sel1,
   output logic [DEV_W-1:0] sel_dev,
   output logic             cs_en,
   output logic             to_f,
   output logic             to_u
);

   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_MAX - 1);
   localparam logic [HOLD_W-1:0] GUARD_LAST = HOLD_W'(GUARD_CYC - 1);
   localparam logic [HOLD_W-1:0] CNT_ONE    = HOLD_W'(1);

   logic [1:0]        state_q,   state_d;
   logic [HOLD_W-1:0] cnt_q,     cnt_d;
   logic              gnt_f_q,   gnt_f_d;
   logic              gnt_u_q,   gnt_u_d;
   logic              sel1_q,    sel1_d;
   dev_t              sel_dev_q, sel_dev_d;
   logic              cs_en_q,   cs_en_d;
   logic              to_f_q,    to_f_d;
   logic              to_u_q,    to_u_d;
   logic              last_q,    last_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gnt_f_d   = 1'b0;
      gnt_u_d   = 1'b0;
      cs_en_d   = 1'b0;
      to_f_d    = 1'b0;
      to_u_d    = 1'b0;
      sel1_d    = sel1_q;
      sel_dev_d = sel_dev_q;
      last_d    = last_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            // On a tie the master that did not own the bank last wins.
            if (req_f && (!req_u || last_q == OWNER_U)) begin
               state_d   = GNT_F;
               gnt_f_d   = 1'b1;
               cs_en_d   = 1'b1;
               sel1_d    = OWNER_F;
               sel_dev_d = dev_f;
            end else if (req_u) begin
               state_d   = GNT_U;
               gnt_u_d   = 1'b1;
               cs_en_d   = 1'b1;
               sel1_d    = OWNER_U;
               sel_dev_d = dev_u;
            end
         end

         GNT_F: begin
            if (rel_f || !req_f) begin
               state_d = GUARD;
               cnt_d   = '0;
               last_d  = OWNER_F;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = GUARD;
               cnt_d   = '0;
               last_d  = OWNER_F;
               to_f_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               gnt_f_d = 1'b1;
               cs_en_d = 1'b1;
            end
         end

         GNT_U: begin
            if (rel_u || !req_u) begin
               state_d = GUARD;
               cnt_d   = '0;
               last_d  = OWNER_U;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = GUARD;
               cnt_d   = '0;
               last_d  = OWNER_U;
               to_u_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               gnt_u_d = 1'b1;
               cs_en_d = 1'b1;
            end
         end

         GUARD: begin
            // sel1/sel_dev stay put so the mux is stable while CS is off.
            if (cnt_q == GUARD_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         gnt_f_q   <= 1'b0;
         gnt_u_q   <= 1'b0;
         sel1_q    <= 1'b0;
         sel_dev_q <= '0;
         cs_en_q   <= 1'b0;
         to_f_q    <= 1'b0;
         to_u_q    <= 1'b0;
         last_q    <= OWNER_U;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gnt_f_q   <= gnt_f_d;
         gnt_u_q   <= gnt_u_d;
         sel1_q    <= sel1_d;
         sel_dev_q <= sel_dev_d;
         cs_en_q   <= cs_en_d;
         to_f_q    <= to_f_d;
         to_u_q    <= to_u_d;
         last_q    <= last_d;
      end
   end

   assign gnt_f   = gnt_f_q;
   assign gnt_u   = gnt_u_q;
   assign sel1    = sel1_q;
   assign sel_dev = sel_dev_q;
   assign cs_en   = cs_en_q;
   assign to_f    = to_f_q;
   assign to_u    = to_u_q;

endmodule
`default_nettype wire
